rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3: number of sequenced reset domains, range 2..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: initial hold length and inter-stage gap in clk cycles, at least 1.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 256: maximum wait for a domain ack in clk cycles, at least 1.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock.
REQ-005 SHALL have rstin  in  1  synchronous, active-high block reset.
REQ-006 SHALL have pll_lock  in  1  clock-lock indication, already synchronous to clk.
REQ-007 SHALL have sw_rst_req  in  1  single-cycle software/debug request to restart the sequence.
REQ-008 SHALL have dom_ack  in  NUM_DOMAINS  per-domain ready indication, synchronous to clk.
REQ-009 SHALL have dom_rst  out  NUM_DOMAINS  per-domain active-high reset, registered.
REQ-010 SHALL have seq_done  out  1  all domains released.
REQ-011 SHALL have seq_err  out  1  sticky ack-timeout flag.
REQ-012 SHALL have cur_stage  out  $clog2(NUM_DOMAINS)+1  index of the domain being processed.

Function
REQ-013 SHALL implement the FSM states WAIT_LOCK, HOLD, WAIT_ACK, GAP, DONE and ERROR.
REQ-014 WAIT_LOCK: all dom_rst=1; when pll_lock=1 is sampled at edge E0, the FSM SHALL enter HOLD.
REQ-015 HOLD: after HOLD_CYCLES cycles, the FSM SHALL drive dom_rst[0]=0 at edge E0+HOLD_CYCLES and enter WAIT_ACK with stage=0.
REQ-016 WAIT_ACK: when dom_ack[stage] is sampled high at edge Ea, the FSM SHALL enter DONE with seq_done=1 at Ea if stage=NUM_DOMAINS-1; otherwise it SHALL enter GAP.
REQ-017 GAP: the FSM SHALL drive dom_rst[stage+1]=0 and increment stage at edge Ea+HOLD_CYCLES, then return to WAIT_ACK.
REQ-018 Domains SHALL release strictly in index order; a released domain SHALL stay released until a restart event.
REQ-019 If no ack has been seen ACK_TIMEOUT cycles after the release edge, the FSM SHALL enter ERROR at that edge.
REQ-020 On entering ERROR, all dom_rst SHALL go to 1, seq_err SHALL go to 1, and seq_done SHALL go to 0.
REQ-021 seq_err SHALL be cleared only by rstin or sw_rst_req.
REQ-022 Lock loss (pll_lock=0 in any state other than WAIT_LOCK) SHALL set all dom_rst=1, seq_done=0 and stage=0 at the next edge, and SHALL enter WAIT_LOCK.
REQ-023 sw_rst_req=1 in any state SHALL set all dom_rst=1, seq_done=0, seq_err=0 and stage=0 at the next edge, and SHALL enter HOLD if pll_lock=1, else WAIT_LOCK.
REQ-024 Event priority SHALL be: rstin > lock loss > sw_rst_req > timeout > ack.
REQ-025 An ack arriving on the same edge as the timeout expiry SHALL lose, so the FSM enters ERROR.
REQ-026 dom_ack bits for stages other than the current stage SHALL be ignored.
REQ-027 The hold/timeout counter SHALL be sized $clog2(max(HOLD_CYCLES,ACK_TIMEOUT))+1 bits, SHALL never wrap, and SHALL be reloaded on every state entry.

Reset
REQ-028 rstin=1 SHALL force WAIT_LOCK, dom_rst=all-ones, seq_done=0, seq_err=0, cur_stage=0 and counter=0 at the next edge.
REQ-029 Power-up register values SHALL equal the rstin values.
REQ-030 rstin mid-sequence SHALL reassert all already-released domains at the next edge.

Configuration
REQ-031 The macro RST_SEQUENCER_ACK_EN SHALL select the ack handshake.
REQ-032 With RST_SEQUENCER_ACK_EN defined, the block SHALL behave as in REQ-016, REQ-019 and REQ-025.
REQ-033 Without RST_SEQUENCER_ACK_EN, dom_ack SHALL be ignored, WAIT_ACK SHALL act as GAP, and each next domain SHALL release HOLD_CYCLES after the previous release.
REQ-034 Without RST_SEQUENCER_ACK_EN, seq_done SHALL rise HOLD_CYCLES after the last release, ERROR SHALL be unreachable, and seq_err SHALL be tied 0.

Structure
REQ-035 Package rst_seq_pkg SHALL hold the state enum rst_seq_state_t and the default parameter constants.
REQ-036 Sub-module rst_seq_timer SHALL implement the loadable down-counter with a terminal-count output; the FSM and outputs SHALL stay in rst_sequencer.

Verification
Benches SHALL use NUM_DOMAINS=3, HOLD_CYCLES=4, ACK_TIMEOUT=8, with ACK_EN defined unless noted.
REQ-037 Lock at edge 10, each ack 2 cycles after its release -> dom_rst[0] low at 14, dom_rst[1] low at 20, dom_rst[2] low at 26, seq_done high at 28.
REQ-038 Lock at 10, dom_ack[1] never asserted -> ERROR at edge 28, dom_rst=3'b111, seq_err=1; then sw_rst_req -> seq_err=0, sequence restarts.
REQ-039 pll_lock dropped one cycle after dom_rst[1] is released -> dom_rst=3'b111 at the next edge, state WAIT_LOCK, seq_done=0.
REQ-040 Ack and timeout coincident on edge release+8 -> ERROR wins; rstin asserted while in DONE -> all outputs return to reset values at the next edge.
REQ-041 ACK_EN undefined, lock at 10, dom_ack=0 -> releases at 14, 18 and 22, seq_done at 26, seq_err stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state type and default parameters for rst_sequencer.
// Config macro RST_SEQUENCER_ACK_EN is consumed by rst_sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        WAIT_ACK  = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } rst_seq_state_t;

    localparam int DEF_NUM_DOMAINS = 3;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 256;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rst_seq_timer: loadable saturating down-counter, tc high while count is zero.
// Used for hold, gap and ack-timeout intervals.
module rst_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstin,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rstin) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases reset domains in index order after pll lock.
// Define RST_SEQUENCER_ACK_EN to gate each release on the previous domain's ack.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rstin,
    input  logic                         pll_lock,
    input  logic                         sw_rst_req,
    input  logic [NUM_DOMAINS-1:0]       dom_ack,
    output logic [NUM_DOMAINS-1:0]       dom_rst,
    output logic                         seq_done,
    output logic                         seq_err,
    output logic [$clog2(NUM_DOMAINS):0] cur_stage
);

    localparam int SW = $clog2(NUM_DOMAINS) + 1;
    localparam int CW = $clog2(max_int(HOLD_CYCLES, ACK_TIMEOUT)) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
`ifdef RST_SEQUENCER_ACK_EN
    localparam logic [CW-1:0] WAIT_LD = CW'(ACK_TIMEOUT - 1);
`else
    localparam logic [CW-1:0] WAIT_LD = HOLD_LD;
`endif

    rst_seq_state_t          state_q, state_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [NUM_DOMAINS-1:0]  dom_rst_q, dom_rst_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    load;
    logic [CW-1:0]           load_val;
    logic                    tc;
    logic [SW-1:0]           stage_nx;
    logic [NUM_DOMAINS-1:0]  rel_nx;
    logic                    last;

    rst_seq_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rstin    (rstin),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    assign stage_nx = stage_q + SW'(1);
    assign last     = (stage_q == SW'(NUM_DOMAINS - 1));

    always_comb begin
        rel_nx = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (stage_nx == SW'(i)) rel_nx[i] = 1'b1;
        end
    end

`ifdef RST_SEQUENCER_ACK_EN
    logic [NUM_DOMAINS-1:0] cur_oh;
    logic                   ack_hit;

    // Only the ack of the domain currently being waited on counts.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (stage_q == SW'(i)) cur_oh[i] = 1'b1;
        end
    end

    assign ack_hit = |(dom_ack & cur_oh);
`else
    logic unused_ack;
    assign unused_ack = ^dom_ack;
`endif

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        dom_rst_d = dom_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        load      = 1'b0;
        load_val  = '0;
        if (!pll_lock && state_q != WAIT_LOCK) begin
            state_d   = WAIT_LOCK;
            dom_rst_d = '1;
            done_d    = 1'b0;
            stage_d   = '0;
            load      = 1'b1;
        end else if (sw_rst_req) begin
            dom_rst_d = '1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            stage_d   = '0;
            load      = 1'b1;
            if (pll_lock) begin
                state_d  = HOLD;
                load_val = HOLD_LD;
            end else begin
                state_d  = WAIT_LOCK;
            end
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (pll_lock) begin
                        state_d  = HOLD;
                        load     = 1'b1;
                        load_val = HOLD_LD;
                    end
                end
                HOLD: begin
                    if (tc) begin
                        dom_rst_d[0] = 1'b0;
                        stage_d      = '0;
                        state_d      = WAIT_ACK;
                        load         = 1'b1;
                        load_val     = WAIT_LD;
                    end
                end
                WAIT_ACK: begin
`ifdef RST_SEQUENCER_ACK_EN
                    // Timeout is checked first so a coincident ack loses.
                    if (tc) begin
                        state_d   = ERROR;
                        dom_rst_d = '1;
                        done_d    = 1'b0;
                        err_d     = 1'b1;
                        stage_d   = '0;
                        load      = 1'b1;
                    end else if (ack_hit) begin
                        load = 1'b1;
                        if (last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = GAP;
                            load_val = HOLD_LD;
                        end
                    end
`else
                    if (tc) begin
                        load = 1'b1;
                        if (last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            dom_rst_d = dom_rst_q & ~rel_nx;
                            stage_d   = stage_nx;
                            load_val  = HOLD_LD;
                        end
                    end
`endif
                end
                GAP: begin
                    if (tc) begin
                        dom_rst_d = dom_rst_q & ~rel_nx;
                        stage_d   = stage_nx;
                        state_d   = WAIT_ACK;
                        load      = 1'b1;
                        load_val  = WAIT_LD;
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstin) begin
            state_q   <= WAIT_LOCK;
            stage_q   <= '0;
            dom_rst_q <= '1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            dom_rst_q <= dom_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign dom_rst   = dom_rst_q;
    assign seq_done  = done_q;
    assign seq_err   = err_q;
    assign cur_stage = stage_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed vector tables plus random stimulus vs a timeline model.
// Expectations follow RST_SEQUENCER_ACK_EN the same way the design does.
module tb_rst_sequencer;

    localparam int N = 3;
    localparam int H = 4;
    localparam int T = 8;
`ifdef RST_SEQUENCER_ACK_EN
    localparam bit AK = 1'b1;
`else
    localparam bit AK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstin = 1'b1;
    logic       pll_lock = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] dom_ack = '0;
    logic [2:0] dom_rst;
    logic       seq_done;
    logic       seq_err;
    logic [2:0] cur_stage;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_DOMAINS (N),
        .HOLD_CYCLES (H),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rstin      (rstin),
        .pll_lock   (pll_lock),
        .sw_rst_req (sw_rst_req),
        .dom_ack    (dom_ack),
        .dom_rst    (dom_rst),
        .seq_done   (seq_done),
        .seq_err    (seq_err),
        .cur_stage  (cur_stage)
    );

    typedef struct {
        int         n;
        bit         r;
        bit         l;
        bit         s;
        logic [2:0] a;
        logic [2:0] er;
        bit         ed;
        bit         ee;
        logic [2:0] es;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    // Timeline model: how many domains are out of reset and when the next event is due.
    int m_rel = 0;
    bit m_active = 0;
    bit m_wait = 0;
    bit m_done = 0;
    bit m_err = 0;
    bit m_halt = 0;
    int m_tev = 0;
    int m_rel_edge = 0;

    task automatic model_edge(input bit r, input bit l, input bit s, input logic [2:0] a);
        if (r) begin
            m_active = 0; m_rel = 0; m_done = 0; m_err = 0; m_halt = 0; m_wait = 0;
        end else if (m_active && !l) begin
            m_active = 0; m_rel = 0; m_done = 0; m_halt = 0; m_wait = 0;
        end else if (s) begin
            m_rel = 0; m_done = 0; m_err = 0; m_halt = 0; m_wait = 0;
            m_active = l;
            m_tev = n + H;
        end else if (!m_active) begin
            if (l) begin
                m_active = 1;
                m_tev = n + H;
            end
        end else if (!m_halt && !m_done) begin
            if (m_wait) begin
                if (n == m_rel_edge + T) begin
                    m_halt = 1; m_err = 1; m_rel = 0; m_wait = 0;
                end else if (a[2'(m_rel - 1)]) begin
                    m_wait = 0;
                    if (m_rel == N) m_done = 1;
                    else m_tev = n + H;
                end
            end else if (n == m_tev) begin
                if (m_rel == N) begin
                    m_done = 1;
                end else begin
                    m_rel++;
                    if (AK) begin
                        m_wait = 1;
                        m_rel_edge = n;
                    end else begin
                        m_tev = n + H;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [2:0] rv;
        logic [2:0] sv;
        for (int i = 0; i < N; i++) rv[i] = (i >= m_rel);
        sv = (m_rel == 0) ? 3'd0 : 3'(m_rel - 1);
        return {rv, m_done, m_err, sv};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {dom_rst, seq_done, seq_err, cur_stage};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got rst/done/err/stage=%b_%b_%b_%0d required %b_%b_%b_%0d",
                     nm, n, act[7:5], act[4], act[3], act[2:0],
                     exp[7:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic step(input bit r, input bit l, input bit s, input logic [2:0] a);
        rstin = r;
        pll_lock = l;
        sw_rst_req = s;
        dom_ack = a;
        @(posedge clk);
        n++;
        model_edge(r, l, s, a);
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic add(input int cnt, input bit r, input bit l, input bit s, input logic [2:0] a,
                       input logic [2:0] er, input bit ed, input bit ee, input logic [2:0] es);
        vec_t v;
        v.n = cnt; v.r = r; v.l = l; v.s = s; v.a = a;
        v.er = er; v.ed = ed; v.ee = ee; v.es = es;
        tbl.push_back(v);
    endtask

    task automatic build_ack_table();
        // Normal sequence, ack two cycles after each release.
        add(1, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(9, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(4, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b010, 3'b100, 0, 0, 1);
        add(3, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b000, 3'b000, 0, 0, 2);
        add(1, 0, 1, 0, 3'b000, 3'b000, 0, 0, 2);
        add(1, 0, 1, 0, 3'b100, 3'b000, 1, 0, 2);
        add(2, 0, 1, 0, 3'b000, 3'b000, 1, 0, 2);
        // rstin while done
        add(1, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        // Ack 1 never arrives; wrong-stage acks are held high meanwhile.
        add(9, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(4, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(2, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(7, 0, 1, 0, 3'b101, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b101, 3'b111, 0, 1, 0);
        add(2, 0, 1, 0, 3'b000, 3'b111, 0, 1, 0);
        // sw restart clears the error and reruns the hold
        add(1, 0, 1, 1, 3'b000, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        // lock lost one cycle after domain 1 release
        add(1, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(2, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        // ack coincident with timeout expiry
        add(1, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(7, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b010, 3'b111, 0, 1, 0);
        // ack one cycle before expiry still wins
        add(1, 0, 1, 1, 3'b000, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(6, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b010, 3'b100, 0, 0, 1);
        add(3, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b000, 3'b000, 0, 0, 2);
        add(1, 0, 1, 0, 3'b100, 3'b000, 1, 0, 2);
    endtask

    task automatic build_noack_table();
        add(1, 1, 0, 0, 3'b111, 3'b111, 0, 0, 0);
        add(9, 0, 0, 0, 3'b111, 3'b111, 0, 0, 0);
        add(4, 0, 1, 0, 3'b111, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b111, 3'b110, 0, 0, 0);
        add(3, 0, 1, 0, 3'b111, 3'b110, 0, 0, 0);
        add(1, 0, 1, 0, 3'b111, 3'b100, 0, 0, 1);
        add(3, 0, 1, 0, 3'b000, 3'b100, 0, 0, 1);
        add(1, 0, 1, 0, 3'b000, 3'b000, 0, 0, 2);
        add(3, 0, 1, 0, 3'b000, 3'b000, 0, 0, 2);
        add(1, 0, 1, 0, 3'b000, 3'b000, 1, 0, 2);
        add(2, 0, 1, 0, 3'b101, 3'b000, 1, 0, 2);
        add(1, 0, 1, 1, 3'b000, 3'b111, 0, 0, 0);
        add(3, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 1, 0, 3'b000, 3'b110, 0, 0, 0);
        add(1, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 0, 0, 0, 3'b000, 3'b111, 0, 0, 0);
        add(1, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0);
    endtask

    initial begin
        bit lk;
        if (AK) build_ack_table();
        else build_noack_table();

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                step(tbl[k].r, tbl[k].l, tbl[k].s, tbl[k].a);
            end
            chk($sformatf("vec%0d", k), dut_vec(),
                {tbl[k].er, tbl[k].ed, tbl[k].ee, tbl[k].es});
        end

        step(1, 0, 0, 3'b000);
        lk = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (lk) lk = ($urandom_range(0, 119) != 0);
            else    lk = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 299) == 0, lk, $urandom_range(0, 149) == 0,
                 3'($urandom & $urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
